// File: rtl/fixed_point_divider_if.sv
// fixed_point_divider_if: start/done handshake and operand/result bus of the Q16.16 divider
interface fixed_point_divider_if #(parameter int WIDTH = 32);
    logic             i_start;
    logic [WIDTH-1:0] din_1;
    logic [WIDTH-1:0] din_2;
    logic [WIDTH-1:0] dout;
    logic             o_busy;
    logic             o_done;
    logic             o_div_zero;
    modport master (output i_start, din_1, din_2, input dout, o_busy, o_done, o_div_zero);
    modport slave (input i_start, din_1, din_2, output dout, o_busy, o_done, o_div_zero);
endinterface

// File: rtl/fixed_point_divider.sv
// fixed_point_divider: sequential signed fixed-point divider, one restoring quotient bit per clock
module fixed_point_divider #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 16
) (
    input logic i_clk,
    input logic i_rst,
    fixed_point_divider_if.slave bus
);
    localparam int DW = WIDTH + FRAC_BITS;
    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             sign, dz, neg_a;
    logic [WIDTH-1:0] mag_b, rem;
    logic [DW-1:0]    dvd, quo;
    logic [WIDTH-1:0] mag_in_a, mag_in_b, res;
    logic [WIDTH:0]   trial, diff;
    logic             take, ovf_pos, ovf_neg, zero_in;
    // Unsigned negation maps the most negative operand to exactly 2^(WIDTH-1)
    assign mag_in_a = bus.din_1[WIDTH-1] ? -bus.din_1 : bus.din_1;
    assign mag_in_b = bus.din_2[WIDTH-1] ? -bus.din_2 : bus.din_2;
    assign zero_in  = bus.din_2 == '0;
    assign trial    = {rem, dvd[DW-1]};
    assign diff     = trial - {1'b0, mag_b};
    assign take     = trial >= {1'b0, mag_b};
    assign ovf_pos  = quo > DW'(MAX_POS);
    assign ovf_neg  = quo > DW'(MAX_NEG);
    assign res = dz   ? (neg_a ? MAX_NEG : MAX_POS) :
                 sign ? (ovf_neg ? MAX_NEG : -quo[WIDTH-1:0]) :
                        (ovf_pos ? MAX_POS : quo[WIDTH-1:0]);
    // A zero divisor enters CALC on its last count so its result lands one cycle later than acceptance+1
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= IDLE;
            cnt            <= '0;
            sign           <= 1'b0;
            dz             <= 1'b0;
            neg_a          <= 1'b0;
            mag_b          <= '0;
            rem            <= '0;
            dvd            <= '0;
            quo            <= '0;
            bus.dout       <= '0;
            bus.o_busy     <= 1'b0;
            bus.o_done     <= 1'b0;
            bus.o_div_zero <= 1'b0;
        end else begin
            bus.o_done <= 1'b0;
            case (state)
                IDLE: if (bus.i_start) begin
                    sign       <= bus.din_1[WIDTH-1] ^ bus.din_2[WIDTH-1];
                    neg_a      <= bus.din_1[WIDTH-1];
                    dz         <= zero_in;
                    mag_b      <= mag_in_b;
                    dvd        <= {mag_in_a, {FRAC_BITS{1'b0}}};
                    rem        <= '0;
                    quo        <= '0;
                    cnt        <= zero_in ? LAST : '0;
                    bus.o_busy <= 1'b1;
                    state      <= CALC;
                end
                CALC: begin
                    rem   <= take ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
                    quo   <= {quo[DW-2:0], take};
                    dvd   <= dvd << 1;
                    cnt   <= cnt + 1'b1;
                    state <= cnt == LAST ? DONE : CALC;
                end
                DONE: begin
                    bus.dout       <= res;
                    bus.o_div_zero <= dz;
                    bus.o_done     <= 1'b1;
                    bus.o_busy     <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
